// File: rtl/game_controller.sv
// game_controller: top-level sequencer for the shooter datapath.
//
// Walks the game through idle -> start -> armed -> flight -> rearm/over. It drives the
// enemy mover (start_game_en, hit_count), parks or releases the bullet shooter
// (bullet_reset), detects hits and misses, and keeps score, lives and game over.
//
// Ports:
//   clock          in   50 MHz system clock
//   reset          in   synchronous, active-high
//   start_btn      in   start request (level, synchronised)
//   fire_btn       in   fire request (level, synchronised)
//   enemy_x        in   enemy x position
//   bullet_x/y     in   bullet position
//   start_game_en  out  enemy restart/park control
//   hit_count      out  enemy speed level (saturates at 3)
//   bullet_reset   out  holds shooter parked while 1
//   score          out  total hits, saturating at 255
//   lives          out  remaining lives
//   game_over      out  high in the over state
//   state          out  FSM encoding for debug/display
//
// Optional feature: define AUTOFIRE_EN to fire on the fire_btn level instead of its
// rising edge, so a held button refires after every rearm.
module game_controller #(
    parameter logic [27:0] START_HOLD     = 28'd2_500_000,
    parameter logic [27:0] REARM_HOLD     = 28'd25_000_000,
    parameter int unsigned LIVES          = 3,
    parameter int unsigned HITS_PER_LEVEL = 4,
    parameter logic [7:0]  ENEMY_Y        = 8'd100,
    parameter logic [7:0]  ENEMY_W        = 8'd8,
    parameter logic [7:0]  MAX_Y          = 8'd119
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       fire_btn,
    input  logic [7:0] enemy_x,
    input  logic [7:0] bullet_x,
    input  logic [7:0] bullet_y,
    output logic       start_game_en,
    output logic [1:0] hit_count,
    output logic       bullet_reset,
    output logic [7:0] score,
    output logic [2:0] lives,
    output logic       game_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StArmed  = 3'd2,
        StFlight = 3'd3,
        StRearm  = 3'd4,
        StOver   = 3'd5
    } state_t;

    localparam logic [2:0] LivesInit    = 3'(LIVES);
    localparam logic [7:0] HitsPerLevel = 8'(HITS_PER_LEVEL);

    state_t      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [7:0]  level_q, level_d;
    logic [7:0]  score_q, score_d;
    logic [2:0]  lives_q, lives_d;
    logic [1:0]  hit_count_q, hit_count_d;
    logic        fire_btn_d_q;
    logic        start_game_en_q, start_game_en_d;
    logic        bullet_reset_q, bullet_reset_d;
    logic        game_over_q, game_over_d;

    logic        fire_edge, fire_go, hit, miss;
    logic [8:0]  enemy_right;

    always_comb begin
        fire_edge = fire_btn & ~fire_btn_d_q;
`ifdef AUTOFIRE_EN
        fire_go = fire_btn;
`else
        fire_go = fire_edge;
`endif
        // 9-bit right edge so an enemy near x=255 does not wrap its hit window.
        enemy_right = {1'b0, enemy_x} + {1'b0, ENEMY_W};
        hit  = (bullet_y == ENEMY_Y) && (bullet_x >= enemy_x) &&
               ({1'b0, bullet_x} < enemy_right);
        miss = (bullet_y >= MAX_Y);

        state_d     = state_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        score_d     = score_q;
        lives_d     = lives_q;
        hit_count_d = hit_count_q;

        case (state_q)
            StIdle, StOver: begin
                if (start_btn) begin
                    state_d     = StStart;
                    cnt_d       = START_HOLD - 28'd1;
                    score_d     = 8'd0;
                    hit_count_d = 2'd0;
                    level_d     = 8'd0;
                    lives_d     = LivesInit;
                end
            end
            StStart, StRearm: begin
                // Counter was loaded with HOLD-1, so the state lasts exactly HOLD cycles.
                if (cnt_q == 28'd0) begin
                    state_d = StArmed;
                end else begin
                    cnt_d = cnt_q - 28'd1;
                end
            end
            StArmed: begin
                if (fire_go) begin
                    state_d = StFlight;
                end
            end
            StFlight: begin
                if (hit) begin
                    if (score_q != 8'hff) begin
                        score_d = score_q + 8'd1;
                    end
                    if (level_q + 8'd1 == HitsPerLevel) begin
                        level_d = 8'd0;
                        if (hit_count_q != 2'd3) begin
                            hit_count_d = hit_count_q + 2'd1;
                        end
                    end else begin
                        level_d = level_q + 8'd1;
                    end
                    state_d = StRearm;
                    cnt_d   = REARM_HOLD - 28'd1;
                end else if (miss) begin
                    lives_d = lives_q - 3'd1;
                    if (lives_q == 3'd1) begin
                        state_d = StOver;
                    end else begin
                        state_d = StRearm;
                        cnt_d   = REARM_HOLD - 28'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Outputs are registered from the next state so they line up with `state`.
        start_game_en_d = (state_d == StIdle) || (state_d == StStart) || (state_d == StOver);
        bullet_reset_d  = (state_d != StFlight);
        game_over_d     = (state_d == StOver);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            cnt_q           <= 28'd0;
            level_q         <= 8'd0;
            score_q         <= 8'd0;
            lives_q         <= LivesInit;
            hit_count_q     <= 2'd0;
            fire_btn_d_q    <= 1'b0;
            start_game_en_q <= 1'b1;
            bullet_reset_q  <= 1'b1;
            game_over_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            level_q         <= level_d;
            score_q         <= score_d;
            lives_q         <= lives_d;
            hit_count_q     <= hit_count_d;
            fire_btn_d_q    <= fire_btn;
            start_game_en_q <= start_game_en_d;
            bullet_reset_q  <= bullet_reset_d;
            game_over_q     <= game_over_d;
        end
    end

    assign start_game_en = start_game_en_q;
    assign hit_count     = hit_count_q;
    assign bullet_reset  = bullet_reset_q;
    assign score         = score_q;
    assign lives         = lives_q;
    assign game_over     = game_over_q;
    assign state         = state_q;

endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
Top-level game sequencer for the shooter datapath. It drives the enemy mover's start_game_en and hit_count (speed level) inputs, and holds or releases the bullet shooter's reset to arm and fire shots. It detects bullet/enemy collisions and misses, and tracks score, lives, and game over. It sits between the board buttons and the enemy/shoot blocks, on the 50 MHz domain.

Parameters:
START_HOLD, 28'd2_500_000, cycles start_game_en is held in S_START (≥ one enemy move tick).
REARM_HOLD, 28'd25_000_000, cycles bullet_reset is held after a hit/miss (≥ one shooter tick).
LIVES, 3, misses allowed before game over (1..7).
HITS_PER_LEVEL, 4, hits needed per hit_count increment (1..255).
ENEMY_Y, 8'd100, bullet y row at which the enemy row is checked.
ENEMY_W, 8'd8, enemy sprite width in pixels.
MAX_Y, 8'd119, bullet y at or above which a shot counts as a miss.

Ports:
clock  in  1  50 MHz system clock
reset  in  1  synchronous, active-high
start_btn  in  1  start request, level, already synchronised
fire_btn  in  1  fire request, level, already synchronised
enemy_x  in  8  enemy x position
bullet_x  in  8  bullet x position
bullet_y  in  8  bullet y position
start_game_en  out  1  enemy restart/park control
hit_count  out  2  enemy speed level
bullet_reset  out  1  holds shooter parked/unarmed while 1
score  out  8  total hits, saturating
lives  out  3  remaining lives
game_over  out  1  high in S_OVER
state  out  3  FSM state encoding, for debug/display

Behaviour:
- Interface: reset is synchronous, active-high; clock is clock. All state updates occur on posedge clock.
- Reset values: state=S_IDLE, start_game_en=1, hit_count=0, bullet_reset=1, score=0, lives=LIVES, game_over=0. Internal hold counter=0, hit-in-level counter=0, fire_btn delay register=0.
- Reset has priority over all events. Asserting reset mid-operation returns to S_IDLE within one cycle.
- State encoding: S_IDLE=0, S_START=1, S_ARMED=2, S_FLIGHT=3, S_REARM=4, S_OVER=5.
- fire_edge = fire_btn & ~fire_btn_d, where fire_btn_d is fire_btn registered by one cycle.
- S_IDLE: start_game_en=1, bullet_reset=1. When start_btn=1 → S_START; load the hold counter; clear score and hit_count; set lives=LIVES.
- S_START: start_game_en=1, bullet_reset=1. Counter decrements each cycle. When it reaches START_HOLD-1 elapsed, i.e. after exactly START_HOLD cycles in the state → S_ARMED.
- S_ARMED: start_game_en=0, bullet_reset=1. On fire_edge → S_FLIGHT; bullet_reset drops to 0 the next cycle.
- S_FLIGHT: bullet_reset=0. Evaluated every cycle.
  - hit = (bullet_y == ENEMY_Y) && (bullet_x ≥ enemy_x) && (bullet_x < enemy_x + ENEMY_W). The sum is computed 9 bits wide, with no wrap.
  - miss = bullet_y ≥ MAX_Y.
  - Hit and miss in the same cycle: hit wins.
  - On hit: score+1, saturating at 255. The level counter increments; when it reaches HITS_PER_LEVEL it clears and hit_count+1, saturating at 3. Then → S_REARM.
  - On miss: lives-1. If lives was 1 → S_OVER, else → S_REARM.
  - fire_btn is ignored in this state.
- S_REARM: bullet_reset=1 for exactly REARM_HOLD cycles, then → S_ARMED. Collisions are not evaluated here.
- S_OVER: game_over=1, start_game_en=1, bullet_reset=1. score and hit_count are frozen. start_btn=1 → S_START with the same clears as from S_IDLE.
- start_btn in S_ARMED, S_FLIGHT, or S_REARM is ignored.
- All outputs are registered; latency from the triggering input to the output change is one cycle.

Optional Feature:
Macro AUTOFIRE_EN.
- Defined: S_ARMED leaves on fire_btn level (held button gives continuous refire after each rearm).
- Undefined: S_ARMED leaves only on fire_edge; a held button fires once and must be released and re-pressed.

Test Plan:
Test parameters: START_HOLD=4, REARM_HOLD=3, LIVES=3, HITS_PER_LEVEL=2, ENEMY_Y=100, ENEMY_W=8, MAX_Y=119.
1. Reset, then start_btn pulse → state 0→1; start_game_en=1 for 4 cycles, then state=2 with start_game_en=0, bullet_reset=1, lives=3, score=0.
2. In S_ARMED, fire edge; then bullet_y=100, enemy_x=50, bullet_x=57 → score=1, state=4; bullet_reset=1 for 3 cycles, then state=2. Repeat once → score=2, hit_count=1. Boundary: bullet_x=58 gives no hit; bullet_x=49 gives no hit.
3. Enemy_x=250, bullet_x=255, bullet_y=100 → hit (no 8-bit wrap); enemy_x=250, bullet_x=2 → no hit.
4. Three flights ending with bullet_y=119 and no hit → lives 3→2→1, then state=5, game_over=1. Then start_btn → state=1, lives=3, score=0, hit_count=0.
5. Bullet_y=100 and collision with MAX_Y temporarily set to 100 (hit and miss together) → hit counted, lives unchanged. Nine further hits → hit_count saturates at 3. Reset asserted in S_FLIGHT → next cycle all outputs at reset values.
6. Fire_btn held high through rearm → without AUTOFIRE_EN stays in state 2; with AUTOFIRE_EN re-enters state 3 on the cycle after S_REARM exits.
